// File: rtl/counter_pkg.sv
// Shared definitions for the free-running counter and its checker.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } chk_state_e;

    localparam int CNT_WIDTH  = 8;
    localparam int STAT_W_DEF = 16;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] value_q, value_d;

    // Clear wins over a simultaneous increment.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/count_checker.sv
// Checks an observed counter stream for +1 increments, with lock and stats.
module count_checker
    import counter_pkg::*;
#(
    parameter int WIDTH    = CNT_WIDTH,
    parameter int LOCK_LEN = 4,
    parameter int STAT_W   = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    input  logic              clr_stats,
    output logic              locked,
    output logic              err_pulse,
    output logic              restart_pulse,
    output logic [WIDTH-1:0]  expected,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count,
    output logic [STAT_W-1:0] restart_count,
    output logic [1:0]        state
);

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [7:0]       LOCK_V = 8'(LOCK_LEN);

    chk_state_e       state_q, state_d;
    logic [7:0]       run_q, run_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;
    logic             rs_q, rs_d;
    logic             wrap_inc;
    logic [WIDTH-1:0] nxt;
    logic [7:0]       run_inc;

    assign nxt     = count_in + ONE;
    assign run_inc = run_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        exp_d    = exp_q;
        err_d    = 1'b0;
        rs_d     = 1'b0;
        wrap_inc = 1'b0;
        if (count_valid) begin
            unique case (state_q)
                IDLE: begin
                    exp_d   = nxt;
                    run_d   = '0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    exp_d = nxt;
                    if (count_in == exp_q) begin
                        run_d = run_inc;
                        if (run_inc == LOCK_V) begin
                            run_d   = '0;
                            state_d = LOCKED;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    exp_d = nxt;
                    if (count_in == exp_q) begin
                        wrap_inc = (count_in == '0);
                    end else begin
                        // A jump to 0 is the source counter restarting.
                        rs_d    = (count_in == '0);
                        err_d   = (count_in != '0);
                        run_d   = '0;
                        state_d = ACQUIRE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            rs_q    <= rs_d;
        end
    end

    sat_counter #(.W(STAT_W)) u_err (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (err_d),
        .value (err_count)
    );

    sat_counter #(.W(STAT_W)) u_wrap (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (wrap_inc),
        .value (wrap_count)
    );

    sat_counter #(.W(STAT_W)) u_restart (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (rs_d),
        .value (restart_count)
    );

    assign locked        = (state_q == LOCKED);
    assign err_pulse     = err_q;
    assign restart_pulse = rs_q;
    assign expected      = exp_q;
    assign state         = state_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker (default stats and a 2-bit stats copy).
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] cin = '0;
    logic       valid = 1'b0;
    logic       clr = 1'b0;

    logic        l1, e1, r1;
    logic [7:0]  x1;
    logic [15:0] ec1, wc1, rc1;
    logic [1:0]  s1;

    logic        l2, e2, r2;
    logic [7:0]  x2;
    logic [1:0]  ec2, wc2, rc2;
    logic [1:0]  s2;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    count_checker dut1 (
        .clk           (clk),
        .rst           (rst),
        .count_in      (cin),
        .count_valid   (valid),
        .clr_stats     (clr),
        .locked        (l1),
        .err_pulse     (e1),
        .restart_pulse (r1),
        .expected      (x1),
        .err_count     (ec1),
        .wrap_count    (wc1),
        .restart_count (rc1),
        .state         (s1)
    );

    count_checker #(.STAT_W(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .count_in      (cin),
        .count_valid   (valid),
        .clr_stats     (clr),
        .locked        (l2),
        .err_pulse     (e2),
        .restart_pulse (r2),
        .expected      (x2),
        .err_count     (ec2),
        .wrap_count    (wc2),
        .restart_count (rc2),
        .state         (s2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic [7:0] v);
        valid = 1'b1;
        cin   = v;
        tick();
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        valid = 1'b1;
        cin   = 8'h37;
        clr   = 1'b0;
        do_reset();
        valid = 1'b0;
        ntests++;
        if ({s1, l1, e1, r1, x1} !== 13'd0) begin
            nfail++;
            $display("FAIL reset_out got s=%0d l=%b e=%b r=%b x=%0d want 0",
                     s1, l1, e1, r1, x1);
        end
        ntests++;
        if ({ec1, wc1, rc1} !== 48'd0) begin
            nfail++;
            $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0",
                     ec1, wc1, rc1);
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int v = 0; v < 4; v++) smp(8'(v));
        ntests++;
        if (l1 !== 1'b0) begin
            nfail++;
            $display("FAIL lock_early got locked=%b want 0", l1);
        end
        smp(8'd4);
        ntests++;
        if (l1 !== 1'b1 || s1 !== 2'd2 || x1 !== 8'd5) begin
            nfail++;
            $display("FAIL lock_rise got l=%b s=%0d x=%0d want 1/2/5",
                     l1, s1, x1);
        end
        ntests++;
        if (e1 !== 1'b0 || r1 !== 1'b0) begin
            nfail++;
            $display("FAIL lock_pulses got e=%b r=%b want 0/0", e1, r1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int v = 248; v < 253; v++) smp(8'(v));
        smp(8'd253);
        smp(8'd254);
        smp(8'd255);
        ntests++;
        if (wc1 !== 16'd0) begin
            nfail++;
            $display("FAIL wrap_pre got %0d want 0", wc1);
        end
        smp(8'd0);
        ntests++;
        if (wc1 !== 16'd1 || x1 !== 8'd1) begin
            nfail++;
            $display("FAIL wrap_edge got wc=%0d x=%0d want 1/1", wc1, x1);
        end
        smp(8'd1);
        ntests++;
        if (l1 !== 1'b1 || ec1 !== 16'd0 || wc1 !== 16'd1) begin
            nfail++;
            $display("FAIL wrap_post got l=%b ec=%0d wc=%0d want 1/0/1",
                     l1, ec1, wc1);
        end
    endtask

    task automatic test_restart();
        do_reset();
        for (int v = 5; v < 10; v++) smp(8'(v));
        smp(8'd0);
        ntests++;
        if (r1 !== 1'b1 || e1 !== 1'b0 || s1 !== 2'd1 || x1 !== 8'd1) begin
            nfail++;
            $display("FAIL restart_hit got r=%b e=%b s=%0d x=%0d want 1/0/1/1",
                     r1, e1, s1, x1);
        end
        smp(8'd0);
        ntests++;
        if (r1 !== 1'b0 || e1 !== 1'b0 || s1 !== 2'd1) begin
            nfail++;
            $display("FAIL restart_hold got r=%b e=%b s=%0d want 0/0/1",
                     r1, e1, s1);
        end
        smp(8'd0);
        smp(8'd0);
        for (int v = 1; v < 4; v++) smp(8'(v));
        ntests++;
        if (l1 !== 1'b0) begin
            nfail++;
            $display("FAIL restart_early got locked=%b want 0", l1);
        end
        smp(8'd4);
        ntests++;
        if (l1 !== 1'b1) begin
            nfail++;
            $display("FAIL restart_relock got locked=%b want 1", l1);
        end
        smp(8'd5);
        ntests++;
        if (rc1 !== 16'd1 || ec1 !== 16'd0 || l1 !== 1'b1) begin
            nfail++;
            $display("FAIL restart_stats got rc=%0d ec=%0d l=%b want 1/0/1",
                     rc1, ec1, l1);
        end
    endtask

    task automatic test_error();
        do_reset();
        for (int v = 16; v < 21; v++) smp(8'(v));
        smp(8'd22);
        ntests++;
        if (e1 !== 1'b1 || r1 !== 1'b0 || ec1 !== 16'd1) begin
            nfail++;
            $display("FAIL err_hit got e=%b r=%b ec=%0d want 1/0/1",
                     e1, r1, ec1);
        end
        ntests++;
        if (s1 !== 2'd1 || x1 !== 8'd23) begin
            nfail++;
            $display("FAIL err_state got s=%0d x=%0d want 1/23", s1, x1);
        end
        smp(8'd23);
        ntests++;
        if (e1 !== 1'b0) begin
            nfail++;
            $display("FAIL err_width got e=%b want 0", e1);
        end
        smp(8'd24);
        smp(8'd25);
        smp(8'd26);
        ntests++;
        if (l1 !== 1'b1 || ec1 !== 16'd1) begin
            nfail++;
            $display("FAIL err_relock got l=%b ec=%0d want 1/1", l1, ec1);
        end
    endtask

    task automatic test_gap_reset();
        for (int i = 0; i < 5; i++) begin
            valid = 1'b0;
            cin   = 8'(8'hA5 ^ (i * 37));
            tick();
            ntests++;
            if (s1 !== 2'd2 || x1 !== 8'd27 || e1 !== 1'b0
                || r1 !== 1'b0 || ec1 !== 16'd1) begin
                nfail++;
                $display("FAIL gap_hold%0d got s=%0d x=%0d e=%b r=%b ec=%0d",
                         i, s1, x1, e1, r1, ec1);
            end
        end
        valid = 1'b1;
        cin   = 8'd27;
        do_reset();
        valid = 1'b0;
        ntests++;
        if (s1 !== 2'd0 || l1 !== 1'b0 || x1 !== 8'd0
            || {ec1, wc1, rc1} !== 48'd0) begin
            nfail++;
            $display("FAIL mid_reset got s=%0d l=%b x=%0d ec=%0d want 0",
                     s1, l1, x1, ec1);
        end
    endtask

    task automatic test_saturation();
        int b;
        do_reset();
        for (int v = 0; v < 5; v++) smp(8'(v));
        for (int k = 1; k <= 5; k++) begin
            b = 20 * k;
            smp(8'(b));
            for (int j = 1; j <= 4; j++) smp(8'(b + j));
        end
        ntests++;
        if (ec2 !== 2'd3 || ec1 !== 16'd5) begin
            nfail++;
            $display("FAIL sat_err got ec2=%0d ec1=%0d want 3/5", ec2, ec1);
        end
        smp(8'd250);
        for (int v = 251; v < 256; v++) smp(8'(v));
        ntests++;
        if (l2 !== 1'b1 || ec2 !== 2'd3 || wc2 !== 2'd0) begin
            nfail++;
            $display("FAIL sat_hold got l=%b ec=%0d wc=%0d want 1/3/0",
                     l2, ec2, wc2);
        end
        clr = 1'b1;
        smp(8'd0);
        clr = 1'b0;
        ntests++;
        if (wc2 !== 2'd0 || ec2 !== 2'd0 || wc1 !== 16'd0) begin
            nfail++;
            $display("FAIL clr_wins got wc2=%0d ec2=%0d wc1=%0d want 0/0/0",
                     wc2, ec2, wc1);
        end
        ntests++;
        if (l2 !== 1'b1 || x2 !== 8'd1) begin
            nfail++;
            $display("FAIL clr_track got l=%b x=%0d want 1/1", l2, x2);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_restart();
        test_error();
        test_gap_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
